// File: rtl/bus_mux_reg.sv
// Registered shared-bus driver: highest-index enabled source wins each cycle,
// with a sticky multi-driver conflict flag and a saturating conflict counter.
module bus_mux_reg #(
  parameter int N_SRC  = 24,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 5,
  parameter int CNT_W  = 8,
  parameter bit HOLD   = 1'b1
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [N_SRC-1:0]        src_en,
  input  logic [N_SRC*DATA_W-1:0] src_data,
  input  logic                    err_clr,
  output logic [DATA_W-1:0]       bus_out,
  output logic [SEL_W-1:0]        bus_sel,
  output logic                    bus_valid,
  output logic                    conflict,
  output logic [CNT_W-1:0]        conflict_cnt
);

  logic [SEL_W-1:0]  win;
  logic [DATA_W-1:0] win_data;
  logic              any_en;
  logic              multi;

  // Ascending scan: the last enabled index seen is the highest, so it wins.
  // A second hit on the scan marks a multi-driver cycle.
  always_comb begin
    win      = '0;
    win_data = '0;
    any_en   = 1'b0;
    multi    = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (src_en[i]) begin
        if (any_en) multi = 1'b1;
        any_en   = 1'b1;
        win      = SEL_W'(i);
        win_data = src_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      bus_out   <= '0;
      bus_sel   <= '0;
      bus_valid <= 1'b0;
    end else begin
      bus_valid <= any_en;
      if (any_en) begin
        bus_out <= win_data;
        bus_sel <= win;
      end else if (!HOLD) begin
        bus_out <= '0;
        bus_sel <= '0;
      end
    end
  end

  // A conflict on the same edge as err_clr survives: history goes, the new event stays.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      conflict     <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      if (multi)        conflict <= 1'b1;
      else if (err_clr) conflict <= 1'b0;

      if (err_clr)
        conflict_cnt <= multi ? CNT_W'(1) : '0;
      else if (multi && conflict_cnt != '1)
        conflict_cnt <= conflict_cnt + CNT_W'(1);
    end
  end

endmodule
